// File: rtl/lcd_apb_pkg.sv
// Shared constants, state encoding and frame-layout helpers for the LCD update master.
// The APB engine and the frame sequencer both import this package.
package lcd_apb_pkg;

   localparam logic [3:0] OFS_SPO2  = 4'h0;
   localparam logic [3:0] OFS_HEART = 4'h4;
   localparam logic [3:0] OFS_WATT  = 4'h8;
   localparam logic [3:0] OFS_STB   = 4'hC;

   localparam int SPO2_W  = 12;
   localparam int HEART_W = 12;
   localparam int WATT_W  = 20;
   localparam int TMO_W   = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } lcd_state_t;

   // Register offset for transfer index; index 4 is the second strobe write.
   function automatic logic [3:0] reg_ofs(input logic [2:0] idx);
      case (idx)
         3'd0:    reg_ofs = OFS_SPO2;
         3'd1:    reg_ofs = OFS_HEART;
         3'd2:    reg_ofs = OFS_WATT;
         default: reg_ofs = OFS_STB;
      endcase
   endfunction

   // Payload of transfer idx, widened to the largest field; the caller zero-extends.
   function automatic logic [WATT_W-1:0] frame_word(
      input logic [2:0]         idx,
      input logic [SPO2_W-1:0]  spo2,
      input logic [HEART_W-1:0] heart,
      input logic [WATT_W-1:0]  watt
   );
      case (idx)
         3'd0:    frame_word = WATT_W'(spo2);
         3'd1:    frame_word = WATT_W'(heart);
         3'd2:    frame_word = watt;
         3'd3:    frame_word = WATT_W'(1);
         default: frame_word = '0;
      endcase
   endfunction

endpackage

// File: rtl/apb3_master_xfer.sv
// Single-write APB3 engine: SETUP then ACCESS until PREADY or timeout.
// A start offered in the completing ACCESS cycle chains the next write without dropping PSEL.
module apb3_master_xfer
   import lcd_apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  o_fin,
   output logic                  o_slverr,
   output logic                  o_tmo,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERROR
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   lcd_state_t            r_state;
   logic [TMO_W-1:0]      r_tmo_cnt;
   logic                  r_psel;
   logic                  r_penable;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;

   logic w_access;
   logic w_tmo_hit;

   assign w_access  = (r_state == ST_ACCESS);
   assign w_tmo_hit = w_access & ~PREADY & (r_tmo_cnt == TMO_LAST);

   assign o_fin    = (w_access & PREADY) | w_tmo_hit;
   assign o_slverr = w_access & PREADY & PSLVERROR;
   assign o_tmo    = w_tmo_hit;

   assign PADDR   = r_paddr;
   assign PSEL    = r_psel;
   assign PENABLE = r_penable;
   assign PWRITE  = r_psel;
   assign PWDATA  = r_pwdata;

   // NOTE: state and outputs use non-blocking assignments so every register
   // samples the pre-edge value of the others, matching the hardware.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_tmo_cnt <= '0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state  <= ST_SETUP;
                  r_psel   <= 1'b1;
                  r_paddr  <= i_addr;
                  r_pwdata <= i_wdata;
               end
            end
            ST_SETUP: begin
               r_state   <= ST_ACCESS;
               r_penable <= 1'b1;
               r_tmo_cnt <= '0;
            end
            ST_ACCESS: begin
               if (PREADY || w_tmo_hit) begin
                  r_penable <= 1'b0;
                  if (PREADY && i_start) begin
                     r_state  <= ST_SETUP;
                     r_paddr  <= i_addr;
                     r_pwdata <= i_wdata;
                  end else begin
                     r_state <= ST_IDLE;
                     r_psel  <= 1'b0;
                  end
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/apb3_lcd_update_master.sv
// Frame sequencer: accepts one SpO2/heart/power frame and writes it plus the strobe
// to the LCD register bank through the single-write APB engine.
module apb3_lcd_update_master
   import lcd_apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int BASE_ADDR  = 0,
   parameter int TIMEOUT    = 255,
   parameter int STB_PULSE  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [SPO2_W-1:0]     upd_spo2,
   input  logic [HEART_W-1:0]    upd_heart,
   input  logic [WATT_W-1:0]     upd_watt,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERROR,
   output logic                  busy,
   output logic                  done,
   output logic                  err_slv,
   output logic                  err_tmo
);

   localparam logic [2:0] LAST_IDX = (STB_PULSE != 0) ? 3'd4 : 3'd3;

   lcd_state_t         r_state;
   logic [2:0]         r_idx;
   logic [SPO2_W-1:0]  r_spo2;
   logic [HEART_W-1:0] r_heart;
   logic [WATT_W-1:0]  r_watt;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               r_err_slv;
   logic               r_err_tmo;

   logic                  w_accept;
   logic                  w_fin;
   logic                  w_slverr;
   logic                  w_tmo;
   logic                  w_more;
   logic                  w_start;
   logic [2:0]            w_xfer_idx;
   logic [SPO2_W-1:0]     w_spo2;
   logic [HEART_W-1:0]    w_heart;
   logic [WATT_W-1:0]     w_watt;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_unused_prdata;

   assign w_unused_prdata = ^PRDATA;

   assign w_accept = upd_valid & r_ready;
   assign w_more   = (r_state == ST_ACCESS) & w_fin & ~w_slverr & ~w_tmo & (r_idx != LAST_IDX);
   assign w_start  = w_accept | w_more;

   // On accept the first write is launched from the live inputs, before the capture registers load.
   assign w_xfer_idx = w_accept ? 3'd0 : r_idx + 3'd1;
   assign w_spo2     = w_accept ? upd_spo2  : r_spo2;
   assign w_heart    = w_accept ? upd_heart : r_heart;
   assign w_watt     = w_accept ? upd_watt  : r_watt;

   assign w_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(reg_ofs(w_xfer_idx));
   assign w_wdata = DATA_WIDTH'(frame_word(w_xfer_idx, w_spo2, w_heart, w_watt));

   assign upd_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err_slv   = r_err_slv;
   assign err_tmo   = r_err_tmo;

   apb3_master_xfer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .TIMEOUT    (TIMEOUT)
   ) u_xfer (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_start),
      .i_addr    (w_addr),
      .i_wdata   (w_wdata),
      .o_fin     (w_fin),
      .o_slverr  (w_slverr),
      .o_tmo     (w_tmo),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PSLVERROR (PSLVERROR)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_spo2    <= '0;
         r_heart   <= '0;
         r_watt    <= '0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err_slv <= 1'b0;
         r_err_tmo <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_spo2    <= upd_spo2;
                  r_heart   <= upd_heart;
                  r_watt    <= upd_watt;
                  r_idx     <= '0;
                  r_err_slv <= 1'b0;
                  r_err_tmo <= 1'b0;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_SETUP;
               end
            end
            ST_SETUP: r_state <= ST_ACCESS;
            ST_ACCESS: begin
               if (w_fin) begin
                  if (w_more) begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= ST_SETUP;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     if (w_slverr) r_err_slv <= 1'b1;
                     if (w_tmo)    r_err_tmo <= 1'b1;
                  end
               end
            end
            // DONE blocks acceptance for one cycle, guaranteeing a PSEL-low gap between frames.
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
